button_event_arbiter: RTL and testbench

Converts a bank of debounced button lines into a single serialized stream of button events for the game logic, and adds optional hold-to-repeat. It replaces the per-button single-pulse stage:
- each press produces exactly one event;
- a held button produces periodic repeat events;
- events from all buttons share one output port under round-robin arbitration with a valid/ready handshake.

It sits between the debouncers and the game state machine.

---
 rtl/bit_epic_pkg.sv | 27 ++
 rtl/button_event_arbiter_if.sv | 23 ++
 rtl/button_repeat_fsm.sv | 74 +++++++
 rtl/button_event_arbiter.sv | 98 +++++++++
 tb/tb_button_event_arbiter.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/bit_epic_pkg.sv
// Shared types and constant helpers for the button event arbiter.
package bit_epic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HOLD = 2'b01,
        RPT  = 2'b10
    } btn_state_e;

    // Ceiling log2, never smaller than 1 so it can size a vector directly.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p << 1;
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_event_arbiter_if.sv
// Valid/ready event stream from the arbiter to the game logic.
interface button_event_arbiter_if #(
    parameter int unsigned ID_W = 2
) ();
    logic            eventValid;
    logic            eventReady;
    logic [ID_W-1:0] eventId;
    logic            eventRepeat;

    modport master (
        output eventValid,
        output eventId,
        output eventRepeat,
        input  eventReady
    );

    modport slave (
        input  eventValid,
        input  eventId,
        input  eventRepeat,
        output eventReady
    );
endinterface

// File: rtl/button_repeat_fsm.sv
// Per-button press / hold-to-repeat sequencer; emits a one-cycle event strobe.
module button_repeat_fsm
    import bit_epic_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY = 8,
    parameter int unsigned REPEAT_RATE  = 3,
    parameter int unsigned CNT_W        = 4
) (
    input  logic clock,
    input  logic resetN,
    input  logic button,
    output logic evt_c,
    output logic rpt_c
);

    localparam bit               RPT_EN   = (REPEAT_DELAY != 0);
    localparam logic [CNT_W-1:0] DELAY_LD = RPT_EN ? CNT_W'(REPEAT_DELAY - 1) : '0;
    localparam logic [CNT_W-1:0] RATE_LD  = CNT_W'(REPEAT_RATE - 1);

    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter saturates at zero, which also covers the repeat-disabled case.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        evt_c   = 1'b0;
        rpt_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (button) begin
                    state_d = HOLD;
                    evt_c   = 1'b1;
                    cnt_d   = DELAY_LD;
                end
            end
            HOLD: begin
                if (!button) begin
                    state_d = IDLE;
                end else if (cnt_q == '0 && RPT_EN) begin
                    state_d = RPT;
                    evt_c   = 1'b1;
                    rpt_c   = 1'b1;
                    cnt_d   = RATE_LD;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RPT: begin
                if (!button) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    evt_c = 1'b1;
                    rpt_c = 1'b1;
                    cnt_d = RATE_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/button_event_arbiter.sv
// Serializes per-button press/repeat events onto one valid/ready stream, round-robin.
module button_event_arbiter
    import bit_epic_pkg::*;
#(
    parameter int unsigned N_BUTTONS    = 4,
    parameter int unsigned REPEAT_DELAY = 25000000,
    parameter int unsigned REPEAT_RATE  = 5000000,
    parameter int unsigned ID_W         = clog2(N_BUTTONS)
) (
    input  logic                 clock,
    input  logic                 resetN,
    input  logic [N_BUTTONS-1:0] buttons,
    input  logic                 enable,
    button_event_arbiter_if.master ev,
    output logic [N_BUTTONS-1:0] pending,
    output logic                 overrun
);

    localparam int unsigned CNT_W = clog2(max2(REPEAT_DELAY, REPEAT_RATE) + 1);

    logic [N_BUTTONS-1:0] evt_c, rpt_c;
    logic [N_BUTTONS-1:0] rep_q, rep_d, pend_d;
    logic [ID_W-1:0]      ptr_q, gnt_c;
    logic                 gnt_vld_c, free_c, lost_c;

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_fsm
        button_repeat_fsm #(
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE),
            .CNT_W        (CNT_W)
        ) u_fsm (
            .clock  (clock),
            .resetN (resetN),
            .button (buttons[i]),
            .evt_c  (evt_c[i]),
            .rpt_c  (rpt_c[i])
        );
    end

    // Round-robin pick: first pending bit at or above the pointer, wrapping.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        gnt_vld_c = 1'b0;
        gnt_c     = '0;
        for (int unsigned k = 0; k < N_BUTTONS; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= N_BUTTONS) idx = idx - N_BUTTONS;
            if (!gnt_vld_c && pending[ID_W'(idx)]) begin
                gnt_vld_c = 1'b1;
                gnt_c     = ID_W'(idx);
            end
        end
    end

    // A new capture beats a same-edge grant clear; otherwise a capture onto a set bit is lost.
    always_comb begin
        logic clr, set;
        free_c = !ev.eventValid || ev.eventReady;
        lost_c = 1'b0;
        pend_d = pending;
        rep_d  = rep_q;
        for (int i = 0; i < N_BUTTONS; i++) begin
            clr       = free_c && gnt_vld_c && (gnt_c == ID_W'(i));
            set       = evt_c[i] && enable;
            pend_d[i] = set || (pending[i] && !clr);
            if (set) rep_d[i] = rpt_c[i];
            if (set && pending[i] && !clr) lost_c = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            pending        <= '0;
            rep_q          <= '0;
            overrun        <= 1'b0;
            ptr_q          <= '0;
            ev.eventValid  <= 1'b0;
            ev.eventId     <= '0;
            ev.eventRepeat <= 1'b0;
        end else begin
            pending <= pend_d;
            rep_q   <= rep_d;
            overrun <= lost_c;
            if (free_c) begin
                if (gnt_vld_c) begin
                    ev.eventValid  <= 1'b1;
                    ev.eventId     <= gnt_c;
                    ev.eventRepeat <= rep_q[gnt_c];
                    ptr_q          <= (gnt_c == ID_W'(N_BUTTONS - 1)) ? '0 : gnt_c + ID_W'(1);
                end else begin
                    ev.eventValid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Scoreboard bench for button_event_arbiter (4 buttons, delay 8, rate 3).
module tb_button_event_arbiter;
    import bit_epic_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned IW = 2;

    logic          clock = 1'b0;
    logic          resetN;
    logic [N-1:0]  buttons;
    logic          enable;
    logic [N-1:0]  pending;
    logic          overrun;

    button_event_arbiter_if #(.ID_W(IW)) ev ();

    button_event_arbiter #(
        .N_BUTTONS    (N),
        .REPEAT_DELAY (8),
        .REPEAT_RATE  (3),
        .ID_W         (IW)
    ) dut (
        .clock   (clock),
        .resetN  (resetN),
        .buttons (buttons),
        .enable  (enable),
        .ev      (ev.master),
        .pending (pending),
        .overrun (overrun)
    );

    always #5 clock = ~clock;

    typedef struct {
        int id;
        int rep;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   ovr_cnt = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push(input int id, input int rep, input int c);
        exp_t e;
        e.id = id; e.rep = rep; e.cyc = c;
        q.push_back(e);
    endtask

    // Output monitor: pops on accepted beats, checks stall stability, counts overrun pulses.
    initial begin
        bit         prev_stall;
        int         prev_id, prev_rep, avail;
        exp_t       e;
        prev_stall = 1'b0;
        prev_id    = 0;
        prev_rep   = 0;
        forever begin
            @(negedge clock);
            if (!resetN) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && ev.eventValid) begin
                    chk("stall_id", ev.eventId, prev_id);
                    chk("stall_rep", ev.eventRepeat, prev_rep);
                end
                if (ev.eventValid && ev.eventReady) begin
                    avail = q.size();
                    chk("evt_expected", avail != 0, 1);
                    if (avail != 0) begin
                        e = q.pop_front();
                        chk("evt_id", ev.eventId, e.id);
                        chk("evt_rep", ev.eventRepeat, e.rep);
                        if (e.cyc >= 0) chk("evt_cycle", cyc, e.cyc);
                    end
                end
                if (overrun) ovr_cnt++;
                prev_stall = ev.eventValid && !ev.eventReady;
                prev_id    = int'(ev.eventId);
                prev_rep   = int'(ev.eventRepeat);
            end
        end
    end

    initial begin
        int d;
        resetN        = 1'b0;
        buttons       = '0;
        enable        = 1'b1;
        ev.eventReady = 1'b1;
        #22;
        chk("rst_valid", ev.eventValid, 0);
        chk("rst_id", ev.eventId, 0);
        chk("rst_rep", ev.eventRepeat, 0);
        chk("rst_pending", pending, 0);
        chk("rst_overrun", overrun, 0);
        wait_cycles(1);
        resetN = 1'b1;
        wait_cycles(2);

        // Round-robin from pointer 0, then a two-button press after the wrap.
        d = cyc;
        buttons = 4'b1111;
        for (int i = 0; i < 4; i++) push(i, 0, d + 2 + i);
        wait_cycles(2);
        buttons = '0;
        wait_cycles(10);
        chk("rr_drained", q.size(), 0);
        d = cyc;
        buttons = 4'b0011;
        push(0, 0, d + 2);
        push(1, 0, d + 3);
        wait_cycles(2);
        buttons = '0;
        wait_cycles(10);
        chk("rr2_drained", q.size(), 0);

        // Single short press: one event, no repeats.
        d = cyc;
        buttons = 4'b0001;
        push(0, 0, d + 2);
        wait_cycles(4);
        buttons = '0;
        wait_cycles(12);
        chk("single_drained", q.size(), 0);

        // Held 20 cycles: press, repeat after 8, then every 3.
        d = cyc;
        buttons = 4'b0100;
        push(2, 0, d + 2);
        push(2, 1, d + 10);
        push(2, 1, d + 13);
        push(2, 1, d + 16);
        push(2, 1, d + 19);
        wait_cycles(20);
        buttons = '0;
        wait_cycles(20);
        chk("hold_drained", q.size(), 0);

        // Backpressure: button 0 stalls in the output, button 1 captured twice -> one overrun.
        ev.eventReady = 1'b0;
        ovr_cnt = 0;
        buttons = 4'b0001;
        push(0, 0, -1);
        push(1, 0, -1);
        wait_cycles(3);
        buttons = '0;
        wait_cycles(2);
        chk("bp_valid", ev.eventValid, 1);
        chk("bp_id", ev.eventId, 0);
        buttons = 4'b0010;
        wait_cycles(2);
        buttons = '0;
        wait_cycles(2);
        chk("bp_ovr_before", ovr_cnt, 0);
        buttons = 4'b0010;
        wait_cycles(2);
        buttons = '0;
        wait_cycles(2);
        chk("bp_pending", pending, 4'b0010);
        chk("bp_overrun_cnt", ovr_cnt, 1);
        chk("bp_id_stalled", ev.eventId, 0);
        ev.eventReady = 1'b1;
        wait_cycles(10);
        chk("bp_drained", q.size(), 0);
        chk("bp_pending_clr", pending, 0);
        chk("bp_overrun_final", ovr_cnt, 1);

        // Enable low: FSM runs but nothing is captured.
        enable  = 1'b0;
        buttons = 4'b0100;
        wait_cycles(3);
        chk("en_pending", pending, 0);
        chk("en_valid", ev.eventValid, 0);
        buttons = '0;
        wait_cycles(2);
        enable = 1'b1;
        wait_cycles(5);
        chk("en_valid_after", ev.eventValid, 0);

        // Reset mid-repeat with a stalled event and a pending repeat.
        ev.eventReady = 1'b0;
        buttons = 4'b1000;
        wait_cycles(10);
        chk("mr_valid_pre", ev.eventValid, 1);
        chk("mr_pending_pre", pending, 4'b1000);
        #2;
        resetN = 1'b0;
        #1;
        chk("mr_valid", ev.eventValid, 0);
        chk("mr_id", ev.eventId, 0);
        chk("mr_rep", ev.eventRepeat, 0);
        chk("mr_pending", pending, 0);
        chk("mr_overrun", overrun, 0);
        buttons = '0;
        wait_cycles(2);
        resetN = 1'b1;
        ev.eventReady = 1'b1;
        wait_cycles(20);
        chk("mr_quiet_valid", ev.eventValid, 0);
        chk("mr_quiet_pending", pending, 0);
        chk("mr_ovr_total", ovr_cnt, 1);
        chk("final_q_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
